// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, states and error codes for the UART receive frame path.
package uart_pkg;
    localparam logic [7:0] HEADER       = 8'hAA;
    localparam logic [7:0] CMD_SET_BAUD = 8'h01;
    localparam logic [7:0] BAUD_MIN     = 8'd0;
    localparam logic [7:0] BAUD_MAX     = 8'd4;
    localparam logic [1:0] ERR_CSUM     = 2'd0;
    localparam logic [1:0] ERR_LEN      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_BAUD     = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM} state_e;
endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: inter-byte cycle counter; expires at TIMEOUT_CYC-1 unless cleared that cycle.
module uart_rx_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int W = $clog2(TIMEOUT_CYC);
    logic [W-1:0] cnt_q, cnt_d;
    assign expire_o = enable_i && !clear_i && cnt_q == W'(TIMEOUT_CYC - 1);
    assign cnt_d = (clear_i || !enable_i || expire_o) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses AA/CMD/LEN/payload/CSUM frames, streams payload and
// applies baud-change commands only while the receiver is idle.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_done_i,
    input  logic       rx_state_i,
    output logic [2:0] baud_sel_o,
    output logic [7:0] data_o,
    output logic       data_vld_o,
    output logic [7:0] frame_cmd_o,
    output logic [7:0] frame_len_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);
    localparam int CW = $clog2(MAX_LEN + 1);
    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d, len_q, len_d, sum_q, sum_d, data_q, data_d, arg_q, arg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      baud_q, baud_d, pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d, vld_q, vld_d, ok_q, ok_d, err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            expire, is_baud;

    uart_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (rx_done_i),
        .enable_i (state_q != S_IDLE),
        .expire_o (expire)
    );

    assign is_baud = cmd_q == CMD_SET_BAUD;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        sum_d      = sum_q;
        data_d     = data_q;
        arg_d      = arg_q;
        cnt_d      = cnt_q;
        baud_d     = baud_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        code_d     = code_q;
        vld_d      = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        if (rx_done_i) begin
            case (state_q)
                S_IDLE: state_d = (rx_byte_i == HEADER) ? S_CMD : S_IDLE;
                S_CMD: begin
                    cmd_d   = rx_byte_i;
                    sum_d   = rx_byte_i;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    len_d = rx_byte_i;
                    sum_d = sum_q + rx_byte_i;
                    cnt_d = CW'(rx_byte_i);
                    if (int'(rx_byte_i) > MAX_LEN || (is_baud && rx_byte_i != 8'd1)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = S_IDLE;
                    end else begin
                        state_d = (rx_byte_i == 8'd0) ? S_CSUM : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    sum_d   = sum_q + rx_byte_i;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_q == CW'(1)) ? S_CSUM : S_PAYLOAD;
                    arg_d   = is_baud ? rx_byte_i : arg_q;
                    data_d  = is_baud ? data_q : rx_byte_i;
                    vld_d   = !is_baud;
                end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (rx_byte_i != sum_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end else if (is_baud && (arg_q > BAUD_MAX || arg_q < BAUD_MIN)) begin
                        err_d  = 1'b1;
                        code_d = ERR_BAUD;
                    end else begin
                        ok_d       = 1'b1;
                        pend_d     = is_baud ? arg_q[2:0] : pend_q;
                        pend_vld_d = pend_vld_q || is_baud;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_IDLE;
        end
        // Blocking on ok_q keeps the baud switch at least two cycles behind Frame_ok.
        if (pend_vld_q && !ok_q && !rx_state_i && !rx_done_i) begin
            baud_d     = pend_q;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            data_q     <= '0;
            arg_q      <= '0;
            cnt_q      <= '0;
            baud_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            code_q     <= '0;
            vld_q      <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            data_q     <= data_d;
            arg_q      <= arg_d;
            cnt_q      <= cnt_d;
            baud_q     <= baud_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            code_q     <= code_d;
            vld_q      <= vld_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign baud_sel_o  = baud_q;
    assign data_o      = data_q;
    assign data_vld_o  = vld_q;
    assign frame_cmd_o = cmd_q;
    assign frame_len_o = len_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = err_q;
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames against a frame-level expectation model.
module tb_uart_rx_frame_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TO      = 40;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       rx_done = 1'b0, rx_state = 1'b0;
    logic [2:0] baud_sel;
    logic [7:0] data, frame_cmd, frame_len;
    logic       data_vld, frame_ok, frame_err;
    logic [1:0] err_code;
    int         total = 0, bad = 0;
    logic [2:0] model_baud = '0;

    uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_byte_i(rx_byte), .rx_done_i(rx_done),
        .rx_state_i(rx_state), .baud_sel_o(baud_sel), .data_o(data), .data_vld_o(data_vld),
        .frame_cmd_o(frame_cmd), .frame_len_o(frame_len), .frame_ok_o(frame_ok),
        .frame_err_o(frame_err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int g();
        return int'($urandom_range(0, 2));
    endfunction

    // One byte: Rx_done sampled on the next edge, outputs checked half a cycle after it.
    task automatic send(input logic [7:0] b, input int gap, input bit e_vld, input bit e_ok,
                        input bit e_err, input logic [1:0] e_code);
        rx_state = 1'b1;
        repeat (gap) @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done  = 1'b0;
        rx_state = 1'b0;
        chk("data_vld", data_vld, e_vld);
        if (e_vld) chk("data", data, b);
        chk("frame_ok", frame_ok, e_ok);
        chk("frame_err", frame_err, e_err);
        if (e_err) chk("err_code", err_code, e_code);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int len, input bq_t pl,
                             input logic [7:0] delta, input int hold);
        logic [7:0] sum;
        logic [1:0] code;
        bit baud, len_err, ok;
        baud    = cmd == 8'h01;
        len_err = len > MAX_LEN || (baud && len != 1);
        send(8'hAA, g(), 0, 0, 0, 2'd0);
        send(cmd, g(), 0, 0, 0, 2'd0);
        send(8'(len), g(), 0, 0, len_err, 2'd1);
        chk("frame_cmd", frame_cmd, cmd);
        chk("frame_len", frame_len, 8'(len));
        if (!len_err) begin
            sum = cmd + 8'(len);
            for (int i = 0; i < len; i++) begin
                send(pl[i], g(), !baud, 0, 0, 2'd0);
                sum = sum + pl[i];
            end
            ok   = 1'b0;
            code = 2'd0;
            if (delta != 8'd0) code = 2'd0;
            else if (baud && pl[0] > 8'd4) code = 2'd3;
            else ok = 1'b1;
            send(sum + delta, g(), 0, ok, !ok, code);
            chk("baud_at_ok", baud_sel, model_baud);
            if (hold > 0) begin
                rx_state = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    chk("baud_busy", baud_sel, model_baud);
                end
                rx_state = 1'b0;
            end else begin
                @(negedge clk);
                chk("baud_latency", baud_sel, model_baud);
            end
            if (ok && baud) model_baud = pl[0][2:0];
        end
        repeat (2) @(negedge clk);
        chk("baud_sel", baud_sel, model_baud);
    endtask

    initial begin
        bq_t pl;
        int  len;
        logic [7:0] cmd, delta;
        repeat (2) @(negedge clk);
        chk("rst_baud", baud_sel, 0);
        chk("rst_data", data, 0);
        chk("rst_vld", data_vld, 0);
        chk("rst_cmd", frame_cmd, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        @(negedge clk);
        pl = {8'h11, 8'h22, 8'h33};
        run_frame(8'h10, 3, pl, 8'd0, 0);
        pl = {8'h04};
        run_frame(8'h01, 1, pl, 8'd0, 0);
        pl = {8'h02};
        run_frame(8'h01, 1, pl, 8'd0, 100);
        pl = {8'h55};
        run_frame(8'h10, 1, pl, 8'hAB, 0);
        pl = {8'hC3, 8'h3C};
        run_frame(8'h22, 2, pl, 8'd0, 0);
        pl.delete();
        run_frame(8'h10, 17, pl, 8'd0, 0);
        run_frame(8'h01, 2, pl, 8'd0, 0);
        pl = {8'h07};
        run_frame(8'h01, 1, pl, 8'd0, 0);
        pl.delete();
        run_frame(8'h33, 0, pl, 8'd0, 0);
        pl = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame(8'hF0, 16, pl, 8'd0, 0);
        send(8'h55, 1, 0, 0, 0, 2'd0);
        send(8'h10, 1, 0, 0, 0, 2'd0);
        pl = {8'h01};
        run_frame(8'h20, 1, pl, 8'd0, 0);
        send(8'hAA, 0, 0, 0, 0, 2'd0);
        send(8'h10, 0, 0, 0, 0, 2'd0);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            chk("no_early_timeout", frame_err, 0);
        end
        @(negedge clk);
        chk("timeout_err", frame_err, 1);
        chk("timeout_code", err_code, 2);
        @(negedge clk);
        chk("timeout_pulse_len", frame_err, 0);
        send(8'hAA, 0, 0, 0, 0, 2'd0);
        send(8'h10, 0, 0, 0, 0, 2'd0);
        send(8'h00, TO - 1, 0, 0, 0, 2'd0);
        send(8'h10, 0, 0, 1, 0, 2'd0);
        for (int f = 0; f < 30; f++) begin
            cmd = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'($urandom_range(0, 255));
            if (cmd == 8'h01) len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 1;
            else len = int'($urandom_range(0, MAX_LEN + 2));
            pl.delete();
            for (int i = 0; i < len; i++)
                pl.push_back(cmd == 8'h01 ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)));
            delta = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_frame(cmd, len, pl, delta, ($urandom_range(0, 3) == 0) ? 5 : 0);
        end
        pl = {8'h03};
        run_frame(8'h01, 1, pl, 8'd0, 0);
        send(8'hAA, 0, 0, 0, 0, 2'd0);
        send(8'h10, 0, 0, 0, 0, 2'd0);
        send(8'h03, 0, 0, 0, 0, 2'd0);
        send(8'h11, 0, 1, 0, 0, 2'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_baud", baud_sel, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_vld", data_vld, 0);
        chk("mid_rst_cmd", frame_cmd, 0);
        chk("mid_rst_len", frame_len, 0);
        chk("mid_rst_ok", frame_ok, 0);
        chk("mid_rst_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_baud = '0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_err", frame_err, 0);
            chk("post_rst_ok", frame_ok, 0);
            chk("post_rst_baud", baud_sel, 0);
        end
        pl = {8'h11, 8'h22, 8'h33};
        run_frame(8'h10, 3, pl, 8'd0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
